// File: rtl/io_tx_stream_ctrl.sv
// Purpose : scans an (nrows+1) x (ncols+1) window out of the image SRAM in raster or
//           column-major order and streams it out with line/frame markers.
// Latency : first m_valid RD_LAT+1 cycles after the start edge; 1 pixel/clk steady state.
// Backpressure: reads are issued only against free output-FIFO credits, so m_ready may stall freely.
// Ports   : clk/rst (sync, active-high); start/abort/col_major/nrows/ncols frame control;
//           sram_rd_en/sram_row/sram_col/sram_dout SRAM read port; m_data/m_valid/m_ready/
//           m_eol/m_eof output stream; busy/done frame status.
module io_tx_stream_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              col_major,
  input  logic [ADDR_W-1:0] nrows,
  input  logic [ADDR_W-1:0] ncols,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_row,
  output logic [ADDR_W-1:0] sram_col,
  input  logic [DATA_W-1:0] sram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t state, state_nxt;

  // Frame configuration captured at start; counters carry one extra bit so a
  // full 2^ADDR_W window never wraps before its last address is reached.
  logic            cm_q;
  logic [ADDR_W:0] nrows_q, ncols_q;
  logic [ADDR_W:0] row_q, col_q;

  logic [ADDR_W:0] inner, outer, inner_lim, outer_lim;
  logic            line_end, frame_end;

  // Read-tag pipe: one stage per cycle of SRAM latency.
  logic [RD_LAT-1:0] pv, peol, peof;
  logic [CW-1:0]     inflight;

  // Output FIFO
  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W+1:0] head;

  logic            push, pop, issue, credit_ok, final_pop, kill;
  logic [CW:0]     reserved;

  assign kill = rst | abort;

  assign inner     = cm_q ? row_q   : col_q;
  assign outer     = cm_q ? col_q   : row_q;
  assign inner_lim = cm_q ? nrows_q : ncols_q;
  assign outer_lim = cm_q ? ncols_q : nrows_q;
  assign line_end  = (inner == inner_lim);
  assign frame_end = line_end && (outer == outer_lim);

  assign push    = pv[RD_LAT-1];
  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;
  assign head    = mem[rd_ptr];

  // Every read already issued owns a FIFO slot; a pop this cycle frees one.
  assign reserved  = {1'b0, count} + {1'b0, inflight};
  assign credit_ok = reserved < ((CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop});

  assign final_pop = (state == S_DRAIN) && pop && head[0];

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (frame_end) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (final_pop) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Abort counts as a completed frame only if one was actually running.
  always_ff @(posedge clk) begin
    if (rst)        done <= 1'b0;
    else if (abort) done <= (state != S_IDLE);
    else            done <= final_pop;
  end

  // Address counters point at the next read and stop on the last address,
  // so the SRAM address lines hold once the frame's reads are done.
  always_ff @(posedge clk) begin
    if (kill) begin
      cm_q    <= 1'b0;
      nrows_q <= '0;
      ncols_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else if (state == S_IDLE && start) begin
      cm_q    <= col_major;
      nrows_q <= {1'b0, nrows};
      ncols_q <= {1'b0, ncols};
      row_q   <= '0;
      col_q   <= '0;
    end else if (issue && !frame_end) begin
      if (!cm_q) begin
        if (col_q == ncols_q) begin
          col_q <= '0;
          row_q <= row_q + ONE;
        end else begin
          col_q <= col_q + ONE;
        end
      end else begin
        if (row_q == nrows_q) begin
          row_q <= '0;
          col_q <= col_q + ONE;
        end else begin
          row_q <= row_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      pv       <= '0;
      peol     <= '0;
      peof     <= '0;
      inflight <= '0;
    end else begin
      pv[0]   <= issue;
      peol[0] <= issue & line_end;
      peof[0] <= issue & frame_end;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]   <= pv[i-1];
        peol[i] <= peol[i-1];
        peof[i] <= peof[i-1];
      end
      inflight <= inflight + CW'(issue) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sram_dout, peol[RD_LAT-1], peof[RD_LAT-1]};
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign sram_rd_en = issue;
  assign sram_row   = row_q[ADDR_W-1:0];
  assign sram_col   = col_q[ADDR_W-1:0];
  assign busy       = (state != S_IDLE);

  // Head fields are masked so stale FIFO contents never show while empty.
  assign m_data = m_valid ? head[DATA_W+1:2] : '0;
  assign m_eol  = m_valid & head[1];
  assign m_eof  = m_valid & head[0];

  // Credit accounting makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst)
                   !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_io_tx_stream_ctrl.sv
module tb_io_tx_stream_ctrl;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int RD_LAT     = 3;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              col_major;
  logic [ADDR_W-1:0] nrows;
  logic [ADDR_W-1:0] ncols;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_row;
  logic [ADDR_W-1:0] sram_col;
  logic [DATA_W-1:0] sram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_eol;
  logic              m_eof;
  logic              busy;
  logic              done;

  io_tx_stream_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .col_major(col_major),
    .nrows(nrows), .ncols(ncols), .sram_rd_en(sram_rd_en), .sram_row(sram_row),
    .sram_col(sram_col), .sram_dout(sram_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_eol(m_eol), .m_eof(m_eof), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              eol;
    logic              eof;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pixel value stored at (r,c): row nibble above column nibble.
  function automatic logic [DATA_W-1:0] pix(input int r, input int c);
    logic [7:0] v;
    v = {r[3:0], c[3:0]};
    return v;
  endfunction

  // Expected beat list straight from the scan-order definition.
  task automatic build(input int nr, input int nc, input bit cm);
    beat_t b;
    exp_q.delete();
    if (!cm) begin
      for (int r = 0; r <= nr; r++)
        for (int c = 0; c <= nc; c++) begin
          b.d = pix(r, c); b.eol = (c == nc); b.eof = (r == nr) && (c == nc);
          exp_q.push_back(b);
        end
    end else begin
      for (int c = 0; c <= nc; c++)
        for (int r = 0; r <= nr; r++) begin
          b.d = pix(r, c); b.eol = (r == nr); b.eof = (r == nr) && (c == nc);
          exp_q.push_back(b);
        end
    end
  endtask

  // SRAM model: request seen mid-cycle, data appears RD_LAT cycles later.
  logic              req_v;
  logic [DATA_W-1:0] req_d;
  logic [DATA_W-1:0] dl [RD_LAT];
  logic [ADDR_W-1:0] last_row, last_col;

  always @(negedge clk) begin
    req_v = sram_rd_en;
    req_d = pix(int'(sram_row), int'(sram_col));
    if (sram_rd_en) begin
      last_row = sram_row;
      last_col = sram_col;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = RD_LAT - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = req_v ? req_d : DATA_W'($urandom);
    sram_dout = dl[RD_LAT-1];
  end

  // Stream monitor: in-order scoreboard, stall stability, outstanding-read bound.
  logic  prev_hold = 1'b0;
  logic [DATA_W+1:0] prev_beat;
  int    outst = 0;
  beat_t b_m;

  always @(negedge clk) begin
    if (prev_hold) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", {m_data, m_eol, m_eof}, prev_beat);
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", m_valid, 0);
      end else begin
        b_m = exp_q.pop_front();
        chk("beat", {m_data, m_eol, m_eof}, {b_m.d, b_m.eol, b_m.eof});
      end
    end
    prev_hold = m_valid && !m_ready && !abort && !rst;
    prev_beat = {m_data, m_eol, m_eof};
    if (rst || abort) outst = 0;
    else outst += int'(sram_rd_en) - int'(m_valid && m_ready);
    if (sram_rd_en || m_valid) chk("credit_bound", outst <= FIFO_DEPTH, 1);
  end

  task automatic drive_ready(input bit rmode);
    m_ready = rmode ? ($urandom_range(0, 9) >= 3) : 1'b1;
  endtask

  task automatic run_frame(input int nr, input int nc, input bit cm, input bit rmode,
                           input bit xstart);
    int cyc, first, ndone, budget;
    build(nr, nc, cm);
    @(posedge clk); #1;
    nrows = ADDR_W'(nr); ncols = ADDR_W'(nc); col_major = cm; start = 1'b1;
    drive_ready(rmode);
    @(posedge clk); #1;
    start = 1'b0;
    drive_ready(rmode);
    cyc = 0; first = -1; ndone = 0;
    budget = (nr + 1) * (nc + 1) * 6 + 40;
    while (cyc < budget) begin
      @(negedge clk);
      if (m_valid && first < 0) first = cyc;
      if (done) begin
        ndone++;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      drive_ready(rmode);
      if (xstart && cyc == 3) begin
        start = 1'b1; nrows = 7; ncols = 7; col_major = ~cm;
      end else begin
        start = 1'b0;
      end
    end
    chk("done_seen", ndone, 1);
    if (!rmode) chk("first_valid_latency", first, RD_LAT + 1);
    chk("frame_complete", exp_q.size(), 0);
    chk("busy_after_done", busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; m_ready = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("post_done_quiet", {done, m_valid, busy}, 0);
    end
  endtask

  task automatic interrupt(input bit use_rst);
    int nb, cyc;
    build(3, 3, 0);
    @(posedge clk); #1;
    nrows = 3; ncols = 3; col_major = 1'b0; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0; cyc = 0;
    while (nb < 5 && cyc < 200) begin
      @(negedge clk);
      if (m_valid && m_ready) nb++;
      if (nb < 5) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("beats_before_interrupt", nb, 5);
    @(posedge clk); #1;
    m_ready = 1'b0;
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("intr_valid", m_valid, 0);
    chk("intr_busy", busy, 0);
    chk("intr_done", done, !use_rst);
    chk("intr_outputs", {sram_rd_en, m_eol, m_eof, m_data, sram_row, sram_col}, 0);
    for (int k = 0; k < RD_LAT + 3; k++) begin
      @(posedge clk); #1; m_ready = 1'b1;
      @(negedge clk);
      chk("late_data_ignored", {m_valid, done, busy}, 0);
    end
    run_frame(3, 3, 0, 0, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; col_major = 1'b0;
    nrows = '0; ncols = '0; m_ready = 1'b1; sram_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_status", {busy, done, sram_rd_en, m_valid, m_eol, m_eof}, 0);
    chk("rst_addr", {sram_row, sram_col}, 0);
    chk("rst_data", m_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(1, 2, 0, 0, 0);
    run_frame(1, 2, 1, 0, 0);
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 0, 1, 0, 0);
    run_frame(3, 3, 0, 1, 0);
    run_frame(3, 3, 1, 1, 0);
    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1, 0);
    run_frame(3, 3, 0, 0, 1);
    interrupt(1'b0);
    interrupt(1'b1);
    run_frame(255, 255, 0, 0, 0);
    chk("last_read_addr", {last_row, last_col}, 16'hFFFF);
    chk("addr_hold", {sram_row, sram_col}, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
